// File: rtl/game_pkg.sv
// Shared types and constants for the two-player battleship turn sequencer.
package game_pkg;

    typedef enum logic [3:0] {
        SETUP_A,
        SETUP_B,
        TURN_A,
        CHECK_A,
        ERR_A,
        TURN_B,
        CHECK_B,
        ERR_B,
        WIN_A,
        WIN_B
    } state_t;

    localparam logic [2:0] DISP_BLANK = 3'd0;
    localparam logic [2:0] DISP_PLACE = 3'd1;
    localparam logic [2:0] DISP_WAIT  = 3'd2;
    localparam logic [2:0] DISP_FIRE  = 3'd3;
    localparam logic [2:0] DISP_ERR   = 3'd4;
    localparam logic [2:0] DISP_WIN   = 3'd5;
    localparam logic [2:0] DISP_LOSE  = 3'd6;

    localparam int ERR_CYCLES_DEF = 50_000_000;
    localparam int SETTLE_DEF     = 2;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw button.
// A press produces a single-cycle evt pulse three clocks after the input rises.
module btn_edge (
    input  logic clk,
    input  logic clr_n,
    input  logic btn,
    output logic evt
);

    logic sync_1;
    logic sync_2;
    logic prev;

    // Synchronize, remember the previous level and register the rising edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            prev   <= sync_2;
            evt    <= sync_2 & ~prev;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Turn sequencer for a two-board battleship game: ship placement, alternating
// fire turns with legality check, timed error display, and win detection.
//
// state   | meaning
// SETUP_A | A places ships, waits for A confirm
// SETUP_B | B places ships, waits for B confirm
// TURN_A  | A to fire
// CHECK_A | A's shot loaded, waiting for LivB to settle
// ERR_A   | A fired an illegal shot, error shown for ERR_CYCLES
// TURN_B  | B to fire
// CHECK_B | B's shot loaded, waiting for LivA to settle
// ERR_B   | B fired an illegal shot, error shown for ERR_CYCLES
// WIN_A   | A sank all of B's ships (terminal until restart)
// WIN_B   | B sank all of A's ships (terminal until restart)
module game_sequencer
    import game_pkg::*;
#(
    parameter int ERR_CYCLES = ERR_CYCLES_DEF,
    parameter int SETTLE     = SETTLE_DEF
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       BTN1A,
    input  logic       BTN2A,
    input  logic       BTN3A,
    input  logic       BTN1B,
    input  logic       BTN2B,
    input  logic       BTN3B,
    input  logic       OKA,
    input  logic       OKB,
    input  logic       LivA,
    input  logic       LivB,
    output logic       ST,
    output logic       LDR2A,
    output logic       LDR2B,
    output logic       clr,
    output logic [2:0] DispA,
    output logic [2:0] DispB,
    output logic       Turn
);

    localparam int ERR_W = cnt_width(ERR_CYCLES);
    localparam int SET_W = cnt_width(SETTLE);
    localparam logic [ERR_W-1:0] ERR_LAST = ERR_W'(ERR_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

    state_t state;
    state_t state_nx;

    logic ev1a, ev2a, ev3a, ev1b, ev2b, ev3b;
    logic restart;
    logic ldr_a_nx;
    logic ldr_b_nx;
    logic err_done;
    logic set_done;
    logic in_err;
    logic in_check;

    logic [ERR_W-1:0] err_cnt;
    logic [SET_W-1:0] set_cnt;

    btn_edge u_btn1a (.clk(clk), .clr_n(clr_n), .btn(BTN1A), .evt(ev1a));
    btn_edge u_btn2a (.clk(clk), .clr_n(clr_n), .btn(BTN2A), .evt(ev2a));
    btn_edge u_btn3a (.clk(clk), .clr_n(clr_n), .btn(BTN3A), .evt(ev3a));
    btn_edge u_btn1b (.clk(clk), .clr_n(clr_n), .btn(BTN1B), .evt(ev1b));
    btn_edge u_btn2b (.clk(clk), .clr_n(clr_n), .btn(BTN2B), .evt(ev2b));
    btn_edge u_btn3b (.clk(clk), .clr_n(clr_n), .btn(BTN3B), .evt(ev3b));

    assign restart  = ev3a | ev3b;
    assign in_err   = (state == ERR_A)   || (state == ERR_B);
    assign in_check = (state == CHECK_A) || (state == CHECK_B);
    assign err_done = (err_cnt == ERR_LAST);
    assign set_done = (set_cnt == SET_LAST);

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= SETUP_A;
        else        state <= state_nx;
    end

    // Next-state and load-strobe decode; restart overrides every other event.
    always_comb begin
        state_nx = state;
        ldr_a_nx = 1'b0;
        ldr_b_nx = 1'b0;
        if (restart) begin
            state_nx = SETUP_A;
        end else begin
            case (state)
                SETUP_A: if (ev1a) state_nx = SETUP_B;
                SETUP_B: if (ev1b) state_nx = TURN_A;
                TURN_A: begin
                    if (ev2a) begin
                        if (OKB) begin
                            state_nx = CHECK_A;
                            ldr_a_nx = 1'b1;
                        end else begin
                            state_nx = ERR_A;
                        end
                    end
                end
                CHECK_A: if (set_done) state_nx = LivB ? TURN_B : WIN_A;
                ERR_A:   if (err_done) state_nx = TURN_A;
                TURN_B: begin
                    if (ev2b) begin
                        if (OKA) begin
                            state_nx = CHECK_B;
                            ldr_b_nx = 1'b1;
                        end else begin
                            state_nx = ERR_B;
                        end
                    end
                end
                CHECK_B: if (set_done) state_nx = LivA ? TURN_A : WIN_B;
                ERR_B:   if (err_done) state_nx = TURN_B;
                WIN_A, WIN_B: state_nx = state;
                default: state_nx = SETUP_A;
            endcase
        end
    end

    // Error and settle counters run only while dwelling in their state and stop at N-1.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_cnt <= '0;
            set_cnt <= '0;
        end else begin
            if (in_err && !restart && !err_done) err_cnt <= err_cnt + 1'b1;
            else                                 err_cnt <= '0;
            if (in_check && !restart && !set_done) set_cnt <= set_cnt + 1'b1;
            else                                   set_cnt <= '0;
        end
    end

    // Registered datapath controls; ST follows the state being entered.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ST    <= 1'b0;
            LDR2A <= 1'b0;
            LDR2B <= 1'b0;
            clr   <= 1'b1;
        end else begin
            ST    <= (state_nx != SETUP_A) && (state_nx != SETUP_B);
            LDR2A <= ldr_a_nx;
            LDR2B <= ldr_b_nx;
            clr   <= restart;
        end
    end

    // Display words and turn indicator decoded from the current state.
    always_comb begin
        DispA = DISP_BLANK;
        DispB = DISP_BLANK;
        Turn  = 1'b0;
        case (state)
            SETUP_A:         begin DispA = DISP_PLACE; DispB = DISP_WAIT;  end
            SETUP_B:         begin DispA = DISP_WAIT;  DispB = DISP_PLACE; end
            TURN_A, CHECK_A: begin DispA = DISP_FIRE;  DispB = DISP_WAIT;  end
            ERR_A:           begin DispA = DISP_ERR;   DispB = DISP_WAIT;  end
            WIN_A:           begin DispA = DISP_WIN;   DispB = DISP_LOSE;  end
            TURN_B, CHECK_B: begin DispA = DISP_WAIT;  DispB = DISP_FIRE;  Turn = 1'b1; end
            ERR_B:           begin DispA = DISP_WAIT;  DispB = DISP_ERR;   Turn = 1'b1; end
            WIN_B:           begin DispA = DISP_LOSE;  DispB = DISP_WIN;   Turn = 1'b1; end
            default:         begin DispA = DISP_BLANK; DispB = DISP_BLANK; end
        endcase
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench: a game-level model predicts every output change with the
// cycle it should appear; a monitor compares each observed change in order.
module tb_game_sequencer;
    import game_pkg::*;

    localparam int ERR_N = 8;
    localparam int SET_N = 2;

    localparam int PH_SETUP = 0;
    localparam int PH_TURN  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_ERR   = 3;
    localparam int PH_WIN   = 4;

    localparam logic [10:0] B_LDRA = 11'h200;
    localparam logic [10:0] B_LDRB = 11'h100;
    localparam logic [10:0] B_CLR  = 11'h080;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic BTN1A = 1'b0, BTN2A = 1'b0, BTN3A = 1'b0;
    logic BTN1B = 1'b0, BTN2B = 1'b0, BTN3B = 1'b0;
    logic OKA = 1'b1, OKB = 1'b1, LivA = 1'b1, LivB = 1'b1;
    logic ST, LDR2A, LDR2B, clr, Turn;
    logic [2:0] DispA, DispB;

    game_sequencer #(.ERR_CYCLES(ERR_N), .SETTLE(SET_N)) dut (
        .clk(clk), .clr_n(clr_n),
        .BTN1A(BTN1A), .BTN2A(BTN2A), .BTN3A(BTN3A),
        .BTN1B(BTN1B), .BTN2B(BTN2B), .BTN3B(BTN3B),
        .OKA(OKA), .OKB(OKB), .LivA(LivA), .LivB(LivB),
        .ST(ST), .LDR2A(LDR2A), .LDR2B(LDR2B), .clr(clr),
        .DispA(DispA), .DispB(DispB), .Turn(Turn)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [10:0] outs;
    } exp_t;

    exp_t        q[$];
    logic [10:0] exp_cur;
    logic [10:0] mon_last;
    logic [10:0] now_t;
    exp_t        mon_e;
    bit          mon_on = 0;
    int          checks = 0;
    int          errors = 0;

    int m_ph = PH_SETUP, m_who = 0;
    bit pend = 0;
    int pend_cyc = 0, pend_ph = 0, pend_who = 0;

    // Observable output word as the game rules describe it for a phase and player.
    function automatic logic [10:0] outs_for(input int ph, input int who);
        logic [2:0] own, oth;
        logic st, turn;
        st   = (ph != PH_SETUP);
        turn = (ph != PH_SETUP) && (who == 1);
        case (ph)
            PH_SETUP:          begin own = DISP_PLACE; oth = DISP_WAIT; end
            PH_TURN, PH_CHECK: begin own = DISP_FIRE;  oth = DISP_WAIT; end
            PH_ERR:            begin own = DISP_ERR;   oth = DISP_WAIT; end
            default:           begin own = DISP_WIN;   oth = DISP_LOSE; end
        endcase
        if (who == 0) return {st, 1'b0, 1'b0, 1'b0, turn, own, oth};
        return {st, 1'b0, 1'b0, 1'b0, turn, oth, own};
    endfunction

    function automatic void expect_at(input int c, input logic [10:0] t);
        logic [10:0] prev;
        exp_t e;
        if (q.size() > 0 && q[$].cyc == c) begin
            e = q[$];
            q.delete(q.size() - 1);
            e.outs = t;
            q.push_back(e);
            return;
        end
        prev = (q.size() > 0) ? q[$].outs : exp_cur;
        if (t != prev) begin
            e.cyc  = c;
            e.outs = t;
            q.push_back(e);
        end
    endfunction

    function automatic void retract_from(input int c);
        while (q.size() > 0 && q[$].cyc >= c) q.delete(q.size() - 1);
    endfunction

    // Game model: apply a set of button events that act on clock edge a.
    function automatic void model_apply(input logic [5:0] m, input int a);
        bit fire, legal, alive;
        if (pend && a > pend_cyc) begin
            m_ph = pend_ph; m_who = pend_who; pend = 0;
        end
        if (m[2] || m[5]) begin
            retract_from(a);
            pend = 0; m_ph = PH_SETUP; m_who = 0;
            expect_at(a, outs_for(PH_SETUP, 0) | B_CLR);
            expect_at(a + 1, outs_for(PH_SETUP, 0));
        end else if (m_ph == PH_SETUP) begin
            if (m_who == 0 && m[0]) begin
                m_who = 1;
                expect_at(a, outs_for(PH_SETUP, 1));
            end else if (m_who == 1 && m[3]) begin
                m_ph = PH_TURN; m_who = 0;
                expect_at(a, outs_for(PH_TURN, 0));
            end
        end else if (m_ph == PH_TURN) begin
            fire  = (m_who == 0) ? m[1] : m[4];
            legal = (m_who == 0) ? OKB : OKA;
            alive = (m_who == 0) ? LivB : LivA;
            if (fire && legal) begin
                m_ph = PH_CHECK;
                expect_at(a, outs_for(PH_CHECK, m_who) | ((m_who == 0) ? B_LDRA : B_LDRB));
                expect_at(a + 1, outs_for(PH_CHECK, m_who));
                pend = 1; pend_cyc = a + SET_N;
                pend_ph  = alive ? PH_TURN : PH_WIN;
                pend_who = alive ? 1 - m_who : m_who;
                expect_at(pend_cyc, outs_for(pend_ph, pend_who));
            end else if (fire) begin
                m_ph = PH_ERR;
                expect_at(a, outs_for(PH_ERR, m_who));
                pend = 1; pend_cyc = a + ERR_N; pend_ph = PH_TURN; pend_who = m_who;
                expect_at(pend_cyc, outs_for(PH_TURN, m_who));
            end
        end
    endfunction

    task automatic press(input logic [5:0] m);
        int n;
        @(posedge clk); #1;
        n = cyc;
        {BTN3B, BTN2B, BTN1B, BTN3A, BTN2A, BTN1A} = m;
        model_apply(m, n + 4);
        repeat (2) @(posedge clk);
        #1;
        {BTN3B, BTN2B, BTN1B, BTN3A, BTN2A, BTN1A} = 6'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (q.size() > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL idle_timeout pending=%0d cyc=%0d", q.size(), cyc);
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: each output change must match the next predicted change and its cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            now_t = {ST, LDR2A, LDR2B, clr, Turn, DispA, DispB};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL missed_change cyc=%0d outputs=%h required %h at cyc %0d",
                         cyc, now_t, q[0].outs, q[0].cyc);
                exp_cur = q[0].outs;
                void'(q.pop_front());
            end
            if (now_t !== mon_last) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d outputs=%h required %h", cyc, now_t, exp_cur);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.outs !== now_t) begin
                        errors++;
                        $display("FAIL change cyc=%0d outputs=%h required %h at cyc %0d",
                                 cyc, now_t, mon_e.outs, mon_e.cyc);
                    end
                    exp_cur = mon_e.outs;
                end
                mon_last = now_t;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  m;
        logic [10:0] rst_t;
        int r, n;
        rst_t = outs_for(PH_SETUP, 0) | B_CLR;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ST, LDR2A, LDR2B, clr, Turn, DispA, DispB} !== rst_t) begin
            errors++;
            $display("FAIL reset_state outputs=%h required %h",
                     {ST, LDR2A, LDR2B, clr, Turn, DispA, DispB}, rst_t);
        end
        exp_cur = rst_t; mon_last = rst_t; mon_on = 1;
        @(posedge clk); #1;
        expect_at(cyc + 1, outs_for(PH_SETUP, 0));
        clr_n = 1'b1;
        wait_idle();

        // Setup: wrong-player and fire buttons ignored, then both confirms.
        press(6'b001000); wait_idle();
        press(6'b001010); wait_idle();
        press(6'b000001); wait_idle();
        press(6'b000001); wait_idle();
        press(6'b001000); wait_idle();

        // A legal shot, B survives.
        OKB = 1; LivB = 1;
        press(6'b000010); wait_idle();
        // B illegal shot, fire during error ignored.
        OKA = 0;
        press(6'b010000); press(6'b010000); wait_idle();
        OKA = 1; LivA = 1;
        press(6'b010000); wait_idle();
        // A illegal shot with ignored re-fire.
        OKB = 0;
        press(6'b000010); press(6'b000010); wait_idle();
        // Simultaneous fire: only A acts.
        OKB = 1; OKA = 1;
        press(6'b010010); wait_idle();
        // B sinks A's last ship; win is terminal until restart.
        LivA = 0;
        press(6'b010000); wait_idle();
        press(6'b010010); wait_idle();
        press(6'b001001); wait_idle();
        press(6'b100000); wait_idle();
        LivA = 1;

        // Fire and restart on the same cycle: restart only.
        press(6'b000001); press(6'b001000); wait_idle();
        press(6'b000110); wait_idle();

        // Randomized play.
        for (int i = 0; i < 60; i++) begin
            OKA  = ($urandom_range(0, 3) != 0);
            OKB  = ($urandom_range(0, 3) != 0);
            LivA = ($urandom_range(0, 4) != 0);
            LivB = ($urandom_range(0, 4) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      m = ($urandom_range(0, 1) != 0) ? 6'b000100 : 6'b100000;
            else if (r <= 2) m = 6'($urandom_range(0, 63)) & 6'b011011;
            else             m = ($urandom_range(0, 1) != 0) ? 6'b000011 : 6'b011000;
            press(m);
            wait_idle();
        end

        // Restart in the middle of an error count.
        LivA = 1; LivB = 1; OKA = 1; OKB = 0;
        press(6'b100000); wait_idle();
        press(6'b000001); press(6'b001000); wait_idle();
        press(6'b000010); press(6'b000100); wait_idle();

        // Asynchronous reset in the middle of an error count.
        press(6'b000001); press(6'b001000); wait_idle();
        press(6'b000010);
        @(posedge clk); #1;
        n = cyc;
        retract_from(n);
        pend = 0; m_ph = PH_SETUP; m_who = 0;
        expect_at(n, rst_t);
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_at(cyc + 1, outs_for(PH_SETUP, 0));
        clr_n = 1'b1;
        wait_idle();
        OKB = 1;
        press(6'b000001); wait_idle();

        repeat (4) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter ERR_CYCLES, default 50_000_000, sets how many clocks the ERR word is held after an illegal attack.
REQ-002 Parameter SETTLE, default 2, sets how many clocks pass after an attack load before the alive flag is sampled.
REQ-003 Port list:
- clk  in  1  system clock.
- clr_n  in  1  asynchronous, active-low reset.
- BTN1A, BTN2A, BTN3A  in  1 each  raw player-A buttons (confirm, fire, restart).
- BTN1B, BTN2B, BTN3B  in  1 each  raw player-B buttons, received from the slave board.
- OKA  in  1  B's attack is legal (exactly one new position), from the master checker.
- OKB  in  1  A's attack is legal, from the slave checker.
- LivA, LivB  in  1 each  player still has ships.
- ST  out  1  0 = ship-load phase, 1 = play phase (datapath mux select).
- LDR2A, LDR2B  out  1 each  one-cycle attack-register load strobes.
- clr  out  1  synchronous clear to the datapath registers.
- DispA, DispB  out  3 each  word selects for each board's seven-segment display.
- Turn  out  1  0 = A to move, 1 = B to move.

Function
REQ-004 Each BTN input SHALL pass through a 2-flop synchronizer and a rising-edge detector, so each press yields exactly one single-cycle event, 3 clocks after the input rises.
REQ-005 FSM states SHALL be SETUP_A, SETUP_B, TURN_A, CHECK_A, ERR_A, TURN_B, CHECK_B, ERR_B, WIN_A, WIN_B.
REQ-006 Transitions:
- SETUP_A: on BTN1A event, go to SETUP_B.
- SETUP_B: on BTN1B event, go to TURN_A.
- Events from the non-owning player SHALL be ignored in both setup states.
REQ-007 TURN_A: on a BTN2A event with OKB=1, pulse LDR2A for one cycle and go to CHECK_A; with OKB=0, go to ERR_A with no strobe.
REQ-008 CHECK_A: wait SETTLE clocks, then go to WIN_A if LivB=0, else to TURN_B.
REQ-009 TURN_B, CHECK_B and ERR_B SHALL mirror REQ-007/008 using BTN2B, OKA, LDR2B and LivA, ending in WIN_B.
REQ-010 ERR_x: count ERR_CYCLES clocks, then return to TURN_x; fire events during ERR_x SHALL be ignored.
REQ-011 WIN_A and WIN_B SHALL be terminal until a restart.
REQ-012 Restart: a BTN3A or BTN3B event in any state SHALL pulse clr for exactly one cycle and move to SETUP_A on the same edge; all counters SHALL clear.
REQ-013 Simultaneous fire events from both players SHALL act only on the player whose turn it is.
REQ-014 Restart SHALL take priority over any other event in the same cycle.
REQ-015 ST SHALL be 0 in SETUP_A and SETUP_B and 1 in all other states; it SHALL be a registered output, decoded from the next state.
REQ-016 Display codes: 0 BLANK, 1 PLACE, 2 WAIT, 3 FIRE, 4 ERR, 5 WIN, 6 LOSE; 7 is unused and never driven.
REQ-017 Display mapping:
- SETUP_A: DispA=PLACE, DispB=WAIT.
- SETUP_B: DispA=WAIT, DispB=PLACE.
- TURN_A and CHECK_A: DispA=FIRE, DispB=WAIT.
- ERR_A: DispA=ERR, DispB=WAIT.
- WIN_A: DispA=WIN, DispB=LOSE.
- The B-side states SHALL use the mirrored mapping.
REQ-018 Turn SHALL be 1 in TURN_B, CHECK_B, ERR_B and WIN_B, and 0 otherwise.
REQ-019 The error and settle counters SHALL be wide enough for their parameters (clog2) and SHALL never wrap; the terminal compare is at N-1.

Reset
REQ-020 While clr_n=0:
- state = SETUP_A, ST=0, LDR2A=LDR2B=0, clr=1, Turn=0, DispA=PLACE, DispB=WAIT.
- All synchronizers, edge detectors and counters are zero.
REQ-021 clr SHALL deassert on the first rising clk edge after clr_n releases.
REQ-022 Asserting clr_n=0 mid-operation SHALL abort any ERR/CHECK count with no residual strobe.

Structure
REQ-023 Package game_pkg SHALL hold the state enum, the 3-bit display-code constants and the default parameter values.
REQ-024 Sub-module btn_edge (synchronizer plus rising-edge detector) SHALL be instantiated six times.

Verification
REQ-025 Reset release -> clr=1 for 1 cycle; DispA=1, DispB=2, ST=0.
REQ-026 BTN1A then BTN1B pulses -> ST rises to 1 as the FSM enters TURN_A; DispA=3; BTN1B pressed during SETUP_A -> no state change.
REQ-027 TURN_A, OKB=1, BTN2A -> LDR2A high exactly 1 cycle; LivB=1 after SETTLE -> Turn=1, DispB=3.
REQ-028 TURN_A, OKB=0, BTN2A (ERR_CYCLES=8) -> DispA=4 for 8 cycles, then 3; no LDR2A pulse.
REQ-029 TURN_B, OKA=1, LivA=0 -> LDR2B pulse, then DispB=5, DispA=6, stays there; BTN2x ignored; BTN3B -> clr pulse, back to SETUP_A.
REQ-030 BTN2A and BTN3A on the same cycle in TURN_A -> restart only, no LDR2A.
